// File: rtl/alarm_sequencer.sv
// alarm_sequencer: rings a beep cadence on a rising hh:mm alarm match, with snooze, stop and auto-timeout.
module alarm_sequencer #(
  parameter int         SLOT_CYCLES = 4800000,
  parameter logic [9:0] PATTERN     = 10'b0001010101,
  parameter int         RING_SEC    = 60,
  parameter int         SNOOZE_SEC  = 300,
  parameter int         MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       armed,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       beep_en,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t state;
  logic [31:0] slot_cnt;
  logic [3:0] slot_idx;
  logic [15:0] sec_cnt;
  logic match, match_q, trigger, slot_end, sec_end, timeout;
  assign match    = (cur_hh == alarm_hh) && (cur_mm == alarm_mm);
  assign trigger  = armed && match && !match_q;
  assign slot_end = slot_cnt == 32'(SLOT_CYCLES - 1);
  assign sec_end  = slot_end && slot_idx == 4'd9;
  // Timeout fires on the edge where sec_cnt would step onto the limit.
  assign timeout  = sec_end && (sec_cnt + 16'd1 == (state == RING ? 16'(RING_SEC) : 16'(SNOOZE_SEC)));
  assign beep_en  = (state == RING) && PATTERN[slot_idx];
  assign ringing  = state == RING;
  assign snoozing = state == SNOOZE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot_cnt <= '0;
      slot_idx <= '0;
      sec_cnt <= '0;
      snooze_cnt <= '0;
      match_q <= 1'b1;
    end else begin
      match_q <= match;
      slot_cnt <= '0;
      slot_idx <= '0;
      sec_cnt <= '0;
      if (state == IDLE) begin
        if (trigger) begin
          state <= RING;
          snooze_cnt <= '0;
        end
      end else if (!armed || stop_btn) begin
        state <= IDLE;
      end else if (state == RING && snooze_btn) begin
        if (snooze_cnt < 2'(MAX_SNOOZE)) begin
          state <= SNOOZE;
          snooze_cnt <= snooze_cnt + 2'd1;
        end else begin
          state <= IDLE;
        end
      end else if (timeout) begin
        state <= (state == RING) ? IDLE : RING;
      end else begin
        slot_cnt <= slot_end ? '0 : slot_cnt + 32'd1;
        slot_idx <= slot_end ? (slot_idx == 4'd9 ? 4'd0 : slot_idx + 4'd1) : slot_idx;
        sec_cnt <= sec_end ? sec_cnt + 16'd1 : sec_cnt;
      end
    end
  end
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed checks of trigger, cadence, timeout, snooze, priority and reset behaviour.
module tb_alarm_sequencer;
  logic clk = 0, rst = 1;
  logic [4:0] cur_hh = 0, alarm_hh = 0;
  logic [5:0] cur_mm = 0, alarm_mm = 0;
  logic armed = 0, stop_btn = 0, snooze_btn = 0;
  logic beep_en, ringing, snoozing;
  logic [1:0] snooze_cnt;
  int total = 0, bad = 0;
  logic [9:0] pat = 10'b0001010101;
  alarm_sequencer #(.SLOT_CYCLES(4), .RING_SEC(3), .SNOOZE_SEC(2), .MAX_SNOOZE(2)) dut (
    .clk(clk), .rst(rst), .cur_hh(cur_hh), .cur_mm(cur_mm), .alarm_hh(alarm_hh),
    .alarm_mm(alarm_mm), .armed(armed), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .beep_en(beep_en), .ringing(ringing), .snoozing(snoozing), .snooze_cnt(snooze_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Packed as {beep_en, ringing, snoozing, snooze_cnt}.
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {beep_en, ringing, snoozing, snooze_cnt};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic set_cur(input int hh, input int mm);
    cur_hh = 5'(hh);
    cur_mm = 6'(mm);
  endtask
  task automatic rise(input int hh, input int mm);
    set_cur(hh, mm == 0 ? 59 : mm - 1);
    if (mm == 0) cur_hh = 5'(hh == 0 ? 23 : hh - 1);
    tick();
    set_cur(hh, mm);
    tick();
  endtask
  task automatic press_snooze();
    snooze_btn = 1;
    tick();
    snooze_btn = 0;
  endtask
  initial begin
    set_cur(12, 0);
    alarm_hh = 12;
    alarm_mm = 0;
    armed = 1;
    tick(2);
    chk("reset_state", 5'b00000);
    rst = 0;
    tick(3);
    chk("no_ring_after_reset_match", 5'b00000);
    armed = 0;
    tick();
    armed = 1;
    tick(2);
    chk("arm_during_match", 5'b00000);
    alarm_hh = 7;
    alarm_mm = 30;
    rise(7, 30);
    for (int k = 0; k < 120; k++) begin
      chk($sformatf("cadence_k%0d", k), {pat[(k / 4) % 10], 1'b1, 1'b0, 2'd0});
      tick();
    end
    chk("timeout_idle", 5'b00000);
    tick(10);
    chk("no_retrigger_held", 5'b00000);
    rise(7, 30);
    tick(5);
    press_snooze();
    for (int k = 0; k < 80; k++) begin
      chk($sformatf("snooze1_k%0d", k), 5'b00101);
      tick();
    end
    chk("resume_slot0", 5'b11001);
    tick(4);
    chk("resume_slot1", 5'b01001);
    press_snooze();
    chk("snooze2", 5'b00110);
    tick(80);
    chk("resume2", 5'b11010);
    press_snooze();
    chk("snooze3_stops", 5'b00010);
    rise(7, 30);
    chk("retrigger_clears_cnt", 5'b11000);
    stop_btn = 1;
    snooze_btn = 1;
    tick();
    stop_btn = 0;
    snooze_btn = 0;
    chk("stop_beats_snooze", 5'b00000);
    rise(7, 30);
    press_snooze();
    chk("snooze_before_disarm", 5'b00101);
    armed = 0;
    tick();
    chk("disarm_in_snooze", 5'b00001);
    armed = 1;
    alarm_hh = 0;
    alarm_mm = 0;
    rise(0, 0);
    chk("midnight_trigger", 5'b11000);
    tick(9);
    rst = 1;
    tick();
    rst = 0;
    chk("reset_mid_ring", 5'b00000);
    tick(5);
    chk("no_rering_after_reset", 5'b00000);
    set_cur(0, 1);
    tick();
    set_cur(0, 0);
    tick();
    chk("rering_new_match", 5'b11000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
